// File: rtl/vpifo_task_dispatcher_pkg.sv
// Shared task record and tree-to-level mapping for the virtual-PIFO task dispatcher.
// These constants must agree with the parameters the dispatcher top is built with.
package vpifo_pkg;

    localparam int PTW       = 16;
    localparam int MTW       = 0;
    localparam int LEVEL     = 4;
    localparam int TREE_NUM  = 8;
    localparam int TREE_ID_W = $clog2(TREE_NUM);
    localparam int DATA_W    = PTW + MTW;
    localparam int LEVEL_W   = (LEVEL > 1) ? $clog2(LEVEL) : 1;

    typedef struct packed {
        logic                 push;
        logic                 pop;
        logic [TREE_ID_W-1:0] tree_id;
        logic [DATA_W-1:0]    data;
    } task_t;

    localparam int TASK_W = $bits(task_t);

    // Each tree lives on exactly one ring level.
    function automatic logic [LEVEL_W-1:0] home_level(input logic [TREE_ID_W-1:0] tree_id);
        return LEVEL_W'(int'(tree_id) % LEVEL);
    endfunction

endpackage

// File: rtl/vpifo_task_dispatcher_fifo.sv
// Per-port first-word-fall-through task FIFO with a registered ready that
// looks at next-state occupancy, so the producer never sees a stale "not full".
module vpifo_task_fifo
    import vpifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              wr_en_i,
    input  logic [TASK_W-1:0] wr_task_i,
    input  logic              rd_en_i,
    output logic [TASK_W-1:0] head_o,
    output logic              empty_o,
    output logic              ready_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TASK_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              full_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en_i && !rd_en_i) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en_i && rd_en_i) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        ready_d = ~full_d;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage is SRAM-like: contents are meaningless until counted in, so no reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_task_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;

endmodule

// File: rtl/vpifo_task_dispatcher.sv
// Ingress scheduler for the virtual-PIFO ring: per-port task FIFOs, per-level
// round-robin arbitration and a per-tree issue-gap guard feeding the ring's rpu_* inputs.
module vpifo_task_dispatcher #(
    parameter int PTW        = 16,
    parameter int MTW        = 0,
    parameter int LEVEL      = 4,
    parameter int TREE_NUM   = 8,
    parameter int N_PORT     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = 4
) (
    input  logic                                       i_clk,
    input  logic                                       i_arst_n,
    input  logic [N_PORT-1:0]                          i_task_valid,
    output logic [N_PORT-1:0]                          o_task_ready,
    input  logic [N_PORT-1:0]                          i_task_push,
    input  logic [N_PORT-1:0]                          i_task_pop,
    input  logic [N_PORT-1:0][$clog2(TREE_NUM)-1:0]    i_task_tree_id,
    input  logic [N_PORT-1:0][PTW+MTW-1:0]             i_task_data,
    input  logic [LEVEL-1:0]                           i_slot_busy,
    output logic [LEVEL-1:0]                           o_rpu_push,
    output logic [LEVEL-1:0]                           o_rpu_pop,
    output logic [LEVEL-1:0][$clog2(TREE_NUM)-1:0]     o_rpu_tree_id,
    output logic [LEVEL-1:0][PTW+MTW-1:0]              o_rpu_push_data,
    output logic [N_PORT-1:0]                          o_fifo_empty,
    output logic [15:0]                                o_err_cnt
);

    import vpifo_pkg::*;

    localparam int TIDW   = $clog2(TREE_NUM);
    localparam int DW     = PTW + MTW;
    localparam int PORT_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam int HZW    = $clog2(ISSUE_GAP + 1);

    logic [N_PORT-1:0]              accept;
    logic [N_PORT-1:0]              null_task;
    logic [N_PORT-1:0]              fifo_wr;
    logic [N_PORT-1:0]              fifo_rd;
    logic [N_PORT-1:0]              fifo_ready;
    logic [N_PORT-1:0]              fifo_empty;
    logic [N_PORT-1:0]              eligible;
    task_t                          head       [N_PORT];
    logic [LEVEL_W-1:0]             head_level [N_PORT];

    logic [LEVEL-1:0]               grant_valid;
    logic [LEVEL-1:0][PORT_W-1:0]   grant_port;
    task_t                          grant_task [LEVEL];

    logic [LEVEL-1:0][PORT_W-1:0]   rr_q, rr_d;
    logic [TREE_NUM-1:0][HZW-1:0]   hazard_q, hazard_d;
    logic [15:0]                    err_q, err_d;
    logic [LEVEL-1:0]               push_q, pop_q;
    logic [LEVEL-1:0][TIDW-1:0]     tree_q;
    logic [LEVEL-1:0][DW-1:0]       data_q;

    // Null tasks complete the handshake but never occupy a FIFO entry.
    for (genvar p = 0; p < N_PORT; p++) begin : g_port
        task_t             in_task;
        logic [TASK_W-1:0] head_bits;

        assign in_task = '{push:    i_task_push[p],
                           pop:     i_task_pop[p],
                           tree_id: i_task_tree_id[p],
                           data:    i_task_data[p]};

        assign null_task[p] = ~(i_task_push[p] | i_task_pop[p]);
        assign accept[p]    = i_task_valid[p] & fifo_ready[p];
        assign fifo_wr[p]   = accept[p] & ~null_task[p];

        vpifo_task_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk     (i_clk),
            .i_arst_n  (i_arst_n),
            .wr_en_i   (fifo_wr[p]),
            .wr_task_i (in_task),
            .rd_en_i   (fifo_rd[p]),
            .head_o    (head_bits),
            .empty_o   (fifo_empty[p]),
            .ready_o   (fifo_ready[p])
        );

        assign head[p]       = task_t'(head_bits);
        assign head_level[p] = home_level(head[p].tree_id);
        assign eligible[p]   = ~fifo_empty[p]
                             & (hazard_q[head[p].tree_id] == '0)
                             & ~i_slot_busy[head_level[p]];
    end

    // Per level, the first eligible port at or after rr_q wins.
    always_comb begin : arb_comb
        logic [PORT_W-1:0] idx;
        idx         = '0;
        grant_valid = '0;
        grant_port  = '0;
        for (int l = 0; l < LEVEL; l++) begin
            for (int k = 0; k < N_PORT; k++) begin
                idx = PORT_W'((int'(rr_q[l]) + k) % N_PORT);
                if (!grant_valid[l] && eligible[idx] && (head_level[idx] == LEVEL_W'(l))) begin
                    grant_valid[l] = 1'b1;
                    grant_port[l]  = idx;
                end
            end
        end
    end

    always_comb begin
        fifo_rd = '0;
        for (int l = 0; l < LEVEL; l++) begin
            grant_task[l] = head[grant_port[l]];
            if (grant_valid[l]) begin
                fifo_rd[grant_port[l]] = 1'b1;
            end
        end
    end

    // A tree maps to one level, so at most one grant per tree per cycle.
    always_comb begin
        rr_d     = rr_q;
        hazard_d = hazard_q;
        for (int t = 0; t < TREE_NUM; t++) begin
            if (hazard_q[t] != '0) begin
                hazard_d[t] = hazard_q[t] - 1'b1;
            end
        end
        for (int l = 0; l < LEVEL; l++) begin
            if (grant_valid[l]) begin
                rr_d[l]                           = PORT_W'((int'(grant_port[l]) + 1) % N_PORT);
                hazard_d[grant_task[l].tree_id]   = HZW'(ISSUE_GAP - 1);
            end
        end
    end

    always_comb begin : err_comb
        logic [16:0] sum;
        sum = {1'b0, err_q};
        for (int p = 0; p < N_PORT; p++) begin
            if (accept[p] && null_task[p]) begin
                sum = sum + 17'd1;
            end
        end
        err_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // Strobes pulse for one cycle; tree/data hold between issues.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rr_q     <= '0;
            hazard_q <= '0;
            err_q    <= '0;
            push_q   <= '0;
            pop_q    <= '0;
            tree_q   <= '0;
            data_q   <= '0;
        end else begin
            rr_q     <= rr_d;
            hazard_q <= hazard_d;
            err_q    <= err_d;
            for (int l = 0; l < LEVEL; l++) begin
                push_q[l] <= grant_valid[l] & grant_task[l].push;
                pop_q[l]  <= grant_valid[l] & grant_task[l].pop;
                if (grant_valid[l]) begin
                    tree_q[l] <= grant_task[l].tree_id;
                    data_q[l] <= grant_task[l].data;
                end
            end
        end
    end

    assign o_task_ready    = fifo_ready;
    assign o_fifo_empty    = fifo_empty;
    assign o_rpu_push      = push_q;
    assign o_rpu_pop       = pop_q;
    assign o_rpu_tree_id   = tree_q;
    assign o_rpu_push_data = data_q;
    assign o_err_cnt       = err_q;

endmodule

// File: tb/tb_vpifo_task_dispatcher.sv
// Directed bench for vpifo_task_dispatcher: reset, latency, hazard spacing,
// round-robin, backpressure under a busy slot, null tasks and mid-run reset.
module tb_vpifo_task_dispatcher;

    logic             i_clk = 1'b0;
    logic             i_arst_n;
    logic [3:0]       i_task_valid;
    logic [3:0]       o_task_ready;
    logic [3:0]       i_task_push;
    logic [3:0]       i_task_pop;
    logic [3:0][2:0]  i_task_tree_id;
    logic [3:0][15:0] i_task_data;
    logic [3:0]       i_slot_busy;
    logic [3:0]       o_rpu_push;
    logic [3:0]       o_rpu_pop;
    logic [3:0][2:0]  o_rpu_tree_id;
    logic [3:0][15:0] o_rpu_push_data;
    logic [3:0]       o_fifo_empty;
    logic [15:0]      o_err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    vpifo_task_dispatcher #(
        .PTW        (16),
        .MTW        (0),
        .LEVEL      (4),
        .TREE_NUM   (8),
        .N_PORT     (4),
        .FIFO_DEPTH (8),
        .ISSUE_GAP  (4)
    ) dut (
        .i_clk           (i_clk),
        .i_arst_n        (i_arst_n),
        .i_task_valid    (i_task_valid),
        .o_task_ready    (o_task_ready),
        .i_task_push     (i_task_push),
        .i_task_pop      (i_task_pop),
        .i_task_tree_id  (i_task_tree_id),
        .i_task_data     (i_task_data),
        .i_slot_busy     (i_slot_busy),
        .o_rpu_push      (o_rpu_push),
        .o_rpu_pop       (o_rpu_pop),
        .o_rpu_tree_id   (o_rpu_tree_id),
        .o_rpu_push_data (o_rpu_push_data),
        .o_fifo_empty    (o_fifo_empty),
        .o_err_cnt       (o_err_cnt)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_task_valid   = '0;
        i_task_push    = '0;
        i_task_pop     = '0;
        i_task_tree_id = '0;
        i_task_data    = '0;
        i_slot_busy    = '0;
    endtask

    // Leaves the bench 1 time unit after the edge that raised ready.
    task automatic do_reset();
        clear_inputs();
        i_arst_n = 1'b0;
        step();
        step();
        i_arst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        i_arst_n = 1'b0;
        #1;
        checks++; if (o_task_ready !== 4'h0) begin errors++; $display("[TB] FAIL reset_ready_low: got %h expected %h", o_task_ready, 4'h0); end
        checks++; if (o_fifo_empty !== 4'hF) begin errors++; $display("[TB] FAIL reset_empty: got %h expected %h", o_fifo_empty, 4'hF); end
        checks++; if ({o_rpu_push, o_rpu_pop} !== 8'h00) begin errors++; $display("[TB] FAIL reset_strobes: got %h expected %h", {o_rpu_push, o_rpu_pop}, 8'h00); end
        checks++; if (o_rpu_tree_id !== 12'h000 || o_rpu_push_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_rpu_regs: got tree %h data %h expected 0", o_rpu_tree_id, o_rpu_push_data); end
        checks++; if (o_err_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %h expected %h", o_err_cnt, 16'h0); end
        repeat (3) step();
        i_arst_n = 1'b1;
        #1;
        checks++; if (o_task_ready !== 4'h0) begin errors++; $display("[TB] FAIL ready_before_edge: got %h expected %h", o_task_ready, 4'h0); end
        step();
        checks++; if (o_task_ready !== 4'hF) begin errors++; $display("[TB] FAIL ready_after_edge: got %h expected %h", o_task_ready, 4'hF); end
    endtask

    task automatic test_single_push();
        do_reset();
        i_task_valid[0]   = 1'b1;
        i_task_push[0]    = 1'b1;
        i_task_tree_id[0] = 3'd5;
        i_task_data[0]    = 16'h1234;
        step();
        clear_inputs();
        checks++; if ({o_rpu_push, o_rpu_pop} !== 8'h00) begin errors++; $display("[TB] FAIL single_c1_strobes: got %h expected %h", {o_rpu_push, o_rpu_pop}, 8'h00); end
        step();
        checks++; if (o_rpu_push !== 4'b0010) begin errors++; $display("[TB] FAIL single_c2_push: got %b expected %b", o_rpu_push, 4'b0010); end
        checks++; if (o_rpu_pop !== 4'b0000) begin errors++; $display("[TB] FAIL single_c2_pop: got %b expected %b", o_rpu_pop, 4'b0000); end
        checks++; if (o_rpu_tree_id[1] !== 3'd5) begin errors++; $display("[TB] FAIL single_tree: got %0d expected %0d", o_rpu_tree_id[1], 5); end
        checks++; if (o_rpu_push_data[1] !== 16'h1234) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", o_rpu_push_data[1], 16'h1234); end
        step();
        checks++; if (o_rpu_push !== 4'b0000) begin errors++; $display("[TB] FAIL single_c3_push: got %b expected %b", o_rpu_push, 4'b0000); end
        checks++; if (o_rpu_tree_id[1] !== 3'd5) begin errors++; $display("[TB] FAIL single_tree_hold: got %0d expected %0d", o_rpu_tree_id[1], 5); end
    endtask

    task automatic test_hazard();
        logic [3:0] exp_pop;
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            clear_inputs();
            if (cyc < 2) begin
                i_task_valid[0]   = 1'b1;
                i_task_pop[0]     = 1'b1;
                i_task_tree_id[0] = 3'd2;
            end
            step();
            exp_pop = (cyc + 1 == 2 || cyc + 1 == 6) ? 4'b0100 : 4'b0000;
            checks++; if (o_rpu_pop !== exp_pop) begin errors++; $display("[TB] FAIL hazard_pop c%0d: got %b expected %b", cyc + 1, o_rpu_pop, exp_pop); end
            checks++; if (o_rpu_push !== 4'b0000) begin errors++; $display("[TB] FAIL hazard_push c%0d: got %b expected %b", cyc + 1, o_rpu_push, 4'b0000); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_push;
        logic [2:0]  exp_tree;
        logic [15:0] exp_data;
        int          c;
        do_reset();
        for (int cyc = 0; cyc < 9; cyc++) begin
            clear_inputs();
            if (cyc == 0) begin
                i_task_valid   = 4'b0111;
                i_task_push    = 4'b0111;
                i_task_tree_id[0] = 3'd1; i_task_data[0] = 16'hA001;
                i_task_tree_id[1] = 3'd5; i_task_data[1] = 16'hA002;
                i_task_tree_id[2] = 3'd1; i_task_data[2] = 16'hA003;
            end
            step();
            c        = cyc + 1;
            exp_push = 4'b0000;
            exp_tree = 3'd0;
            exp_data = 16'h0;
            if (c == 2) begin exp_push = 4'b0010; exp_tree = 3'd1; exp_data = 16'hA001; end
            if (c == 3) begin exp_push = 4'b0010; exp_tree = 3'd5; exp_data = 16'hA002; end
            if (c == 6) begin exp_push = 4'b0010; exp_tree = 3'd1; exp_data = 16'hA003; end
            checks++; if (o_rpu_push !== exp_push) begin errors++; $display("[TB] FAIL rr_push c%0d: got %b expected %b", c, o_rpu_push, exp_push); end
            if (exp_push != 4'b0000) begin
                checks++; if (o_rpu_tree_id[1] !== exp_tree) begin errors++; $display("[TB] FAIL rr_tree c%0d: got %0d expected %0d", c, o_rpu_tree_id[1], exp_tree); end
                checks++; if (o_rpu_push_data[1] !== exp_data) begin errors++; $display("[TB] FAIL rr_data c%0d: got %h expected %h", c, o_rpu_push_data[1], exp_data); end
            end
        end
    endtask

    task automatic test_slot_busy_full();
        int         idx;
        logic       acc;
        logic [3:0] exp_push;
        int         k;
        do_reset();
        idx = 0;
        for (int cyc = 0; cyc < 49; cyc++) begin
            clear_inputs();
            i_slot_busy       = (cyc < 12) ? 4'b1000 : 4'b0000;
            i_task_valid[2]   = (idx < 9);
            i_task_push[2]    = 1'b1;
            i_task_tree_id[2] = 3'd3;
            i_task_data[2]    = 16'(idx);
            acc = i_task_valid[2] & o_task_ready[2];
            if (cyc == 7) begin
                checks++; if (o_task_ready[2] !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_c7: got %b expected %b", o_task_ready[2], 1'b1); end
            end
            if (cyc >= 8 && cyc <= 12) begin
                checks++; if (o_task_ready[2] !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_low c%0d: got %b expected %b", cyc, o_task_ready[2], 1'b0); end
                checks++; if (o_fifo_empty[2] !== 1'b0) begin errors++; $display("[TB] FAIL full_empty c%0d: got %b expected %b", cyc, o_fifo_empty[2], 1'b0); end
            end
            if (cyc == 13) begin
                checks++; if (o_task_ready[2] !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_back: got %b expected %b", o_task_ready[2], 1'b1); end
            end
            k        = (cyc - 13) / 4;
            exp_push = (cyc >= 13 && ((cyc - 13) % 4) == 0 && k <= 8) ? 4'b1000 : 4'b0000;
            checks++; if (o_rpu_push !== exp_push) begin errors++; $display("[TB] FAIL busy_push c%0d: got %b expected %b", cyc, o_rpu_push, exp_push); end
            if (exp_push != 4'b0000) begin
                checks++; if (o_rpu_push_data[3] !== 16'(k)) begin errors++; $display("[TB] FAIL busy_order c%0d: got %h expected %h", cyc, o_rpu_push_data[3], 16'(k)); end
            end
            step();
            if (acc) idx++;
        end
        checks++; if (idx !== 9) begin errors++; $display("[TB] FAIL busy_accepted: got %0d expected %0d", idx, 9); end
        checks++; if (o_fifo_empty[2] !== 1'b1) begin errors++; $display("[TB] FAIL busy_drained: got %b expected %b", o_fifo_empty[2], 1'b1); end
    endtask

    task automatic test_null_task();
        do_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            clear_inputs();
            i_task_valid[3] = 1'b1;
            step();
            checks++; if (o_err_cnt !== 16'(cyc + 1)) begin errors++; $display("[TB] FAIL null_err c%0d: got %0d expected %0d", cyc + 1, o_err_cnt, cyc + 1); end
            checks++; if (o_fifo_empty[3] !== 1'b1) begin errors++; $display("[TB] FAIL null_empty c%0d: got %b expected %b", cyc + 1, o_fifo_empty[3], 1'b1); end
        end
        clear_inputs();
        for (int cyc = 0; cyc < 3; cyc++) begin
            step();
            checks++; if ({o_rpu_push, o_rpu_pop} !== 8'h00) begin errors++; $display("[TB] FAIL null_strobes: got %h expected %h", {o_rpu_push, o_rpu_pop}, 8'h00); end
        end
        checks++; if (o_err_cnt !== 16'd3) begin errors++; $display("[TB] FAIL null_err_final: got %0d expected %0d", o_err_cnt, 3); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_slot_busy = 4'hF;
        for (int cyc = 0; cyc < 2; cyc++) begin
            i_task_valid      = 4'b0011;
            i_task_push       = 4'b0011;
            i_task_tree_id[0] = 3'd0;
            i_task_tree_id[1] = 3'd1;
            step();
        end
        i_task_valid = '0;
        checks++; if (o_fifo_empty[1:0] !== 2'b00) begin errors++; $display("[TB] FAIL mid_queued: got %b expected %b", o_fifo_empty[1:0], 2'b00); end
        i_arst_n = 1'b0;
        #1;
        checks++; if (o_fifo_empty !== 4'hF) begin errors++; $display("[TB] FAIL mid_empty: got %h expected %h", o_fifo_empty, 4'hF); end
        checks++; if (o_task_ready !== 4'h0) begin errors++; $display("[TB] FAIL mid_ready: got %h expected %h", o_task_ready, 4'h0); end
        step();
        i_arst_n    = 1'b1;
        i_slot_busy = 4'h0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step();
            checks++; if ({o_rpu_push, o_rpu_pop} !== 8'h00) begin errors++; $display("[TB] FAIL mid_no_issue c%0d: got %h expected %h", cyc, {o_rpu_push, o_rpu_pop}, 8'h00); end
        end
    endtask

    initial begin
        $display("[TB] starting vpifo_task_dispatcher bench");
        test_reset();
        test_single_push();
        test_hazard();
        test_round_robin();
        test_slot_busy_full();
        test_null_task();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
